// File: rtl/dmi_timeout_bridge.sv
// DMI bridge between the debug transport and the debug module.
// It holds one request at a time and returns exactly one response upstream.
// If the debug module stays silent, the bridge answers with a synthesized
// response. A late answer to a timed-out request is absorbed here.
module dmi_timeout_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              up_req_valid,
    output logic              up_req_ready,
    input  logic [ADDR_W-1:0] up_req_addr,
    input  logic [1:0]        up_req_op,
    input  logic [31:0]       up_req_data,
    output logic              up_resp_valid,
    input  logic              up_resp_ready,
    output logic [1:0]        up_resp_resp,
    output logic [31:0]       up_resp_data,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic [1:0]        dm_req_op,
    output logic [31:0]       dm_req_data,
    input  logic              dm_resp_valid,
    output logic              dm_resp_ready,
    input  logic [1:0]        dm_resp_resp,
    input  logic [31:0]       dm_resp_data,
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_FAILED = 2'd2;
    localparam logic [1:0] RESP_BUSY   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic              drop_pending;
    logic [TW-1:0]     timer;
    logic [7:0]        tcnt;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_op;
    logic [31:0]       req_data;
    logic [1:0]        rsp_resp;
    logic [31:0]       rsp_data;

    logic timer_last;
    assign timer_last = (timer == TIMER_LAST);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Transaction FSM: request capture, issue, response wait, timeout and late-response absorption.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            drop_pending <= 1'b0;
            timer        <= '0;
            tcnt         <= '0;
            req_addr     <= '0;
            req_op       <= '0;
            req_data     <= '0;
            rsp_resp     <= '0;
            rsp_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (drop_pending && dm_resp_valid)
                        drop_pending <= 1'b0;
                    if (up_req_valid) begin
                        req_addr <= up_req_addr;
                        req_op   <= up_req_op;
                        req_data <= up_req_data;
                        timer    <= '0;
                        // A late response absorbed this same cycle frees the path immediately.
                        state    <= (drop_pending && !dm_resp_valid) ? HOLD : ISSUE;
                    end
                end
                HOLD: begin
                    timer <= timer + 1'b1;
                    if (dm_resp_valid) begin
                        drop_pending <= 1'b0;
                        state        <= ISSUE;
                    end else if (timer_last) begin
                        rsp_resp <= RESP_BUSY;
                        rsp_data <= '0;
                        tcnt     <= sat_inc(tcnt);
                        state    <= RESP;
                    end
                end
                ISSUE: begin
                    if (dm_req_ready) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (dm_resp_valid) begin
                        rsp_resp <= dm_resp_resp;
                        rsp_data <= dm_resp_data;
                        state    <= RESP;
                    end else if (timer_last) begin
                        rsp_resp     <= RESP_FAILED;
                        rsp_data     <= '0;
                        drop_pending <= 1'b1;
                        tcnt         <= sat_inc(tcnt);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (drop_pending && dm_resp_valid)
                        drop_pending <= 1'b0;
                    if (up_resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign up_req_ready  = (state == IDLE);
    assign up_resp_valid = (state == RESP);
    assign up_resp_resp  = rsp_resp;
    assign up_resp_data  = rsp_data;
    assign dm_req_valid  = (state == ISSUE);
    assign dm_req_addr   = req_addr;
    assign dm_req_op     = req_op;
    assign dm_req_data   = req_data;
    assign dm_resp_ready = (state == WAIT) || (state == HOLD) ||
                           (((state == IDLE) || (state == RESP)) && drop_pending);
    assign busy          = (state != IDLE);
    assign timeout_cnt   = tcnt;

endmodule

// File: tb/tb_dmi_timeout_bridge.sv
// Scoreboard bench for dmi_timeout_bridge with a 16-cycle timeout.
// Expected dm requests and upstream responses are queued by the stimulus.
// Monitors pop them on each handshake.
module tb_dmi_timeout_bridge;

    logic        clk;
    logic        rstn;
    logic        up_req_valid;
    logic        up_req_ready;
    logic [6:0]  up_req_addr;
    logic [1:0]  up_req_op;
    logic [31:0] up_req_data;
    logic        up_resp_valid;
    logic        up_resp_ready;
    logic [1:0]  up_resp_resp;
    logic [31:0] up_resp_data;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [6:0]  dm_req_addr;
    logic [1:0]  dm_req_op;
    logic [31:0] dm_req_data;
    logic        dm_resp_valid;
    logic        dm_resp_ready;
    logic [1:0]  dm_resp_resp;
    logic [31:0] dm_resp_data;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int passed = 0;
    int total  = 0;

    logic [33:0] up_q[$];
    logic [40:0] dm_q[$];

    dmi_timeout_bridge #(.TIMEOUT_CYCLES(16), .ADDR_W(7)) dut (
        .clk(clk), .rstn(rstn),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
        .up_req_addr(up_req_addr), .up_req_op(up_req_op), .up_req_data(up_req_data),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
        .up_resp_resp(up_resp_resp), .up_resp_data(up_resp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr), .dm_req_op(dm_req_op), .dm_req_data(dm_req_data),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready),
        .dm_resp_resp(dm_resp_resp), .dm_resp_data(dm_resp_data),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Upstream response monitor
    always @(negedge clk) begin
        if (rstn && up_resp_valid && up_resp_ready) begin
            if (up_q.size() == 0) check("up_unexpected_resp", {30'd0, up_resp_resp, up_resp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("up_resp", {30'd0, up_resp_resp, up_resp_data}, {30'd0, up_q.pop_front()});
        end
    end

    // Debug-module request monitor
    always @(negedge clk) begin
        if (rstn && dm_req_valid && dm_req_ready) begin
            if (dm_q.size() == 0) check("dm_unexpected_req", {23'd0, dm_req_addr, dm_req_op, dm_req_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("dm_req", {23'd0, dm_req_addr, dm_req_op, dm_req_data}, {23'd0, dm_q.pop_front()});
        end
    end

    task automatic send_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
        up_req_valid = 1'b1;
        up_req_addr  = a;
        up_req_op    = op;
        up_req_data  = d;
    endtask

    // Normal transaction: dm ready at once, response lat cycles into WAIT
    task automatic txn(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                       input int lat, input logic [1:0] r, input logic [31:0] rd);
        dm_q.push_back({a, op, d});
        up_q.push_back({r, rd});
        check("idle_no_req", dm_req_valid, 1'b0);
        send_req(a, op, d);
        tick(1);
        up_req_valid = 1'b0;
        check("issue_latency", dm_req_valid, 1'b1);
        tick(1);
        if (lat > 0) tick(lat);
        dm_resp_valid = 1'b1;
        dm_resp_resp  = r;
        dm_resp_data  = rd;
        tick(1);
        dm_resp_valid = 1'b0;
        check("resp_present", up_resp_valid, 1'b1);
        check("busy_in_resp", busy, 1'b1);
        tick(1);
        check("busy_falls", busy, 1'b0);
    endtask

    // Silent debug module: failed response exactly 16 cycles after dm handshake
    task automatic txn_timeout(input logic [6:0] a, input logic [1:0] op);
        dm_q.push_back({a, op, 32'd0});
        up_q.push_back({2'd2, 32'd0});
        send_req(a, op, 32'd0);
        tick(1);
        up_req_valid = 1'b0;
        tick(1);
        tick(15);
        check("timeout_not_early", up_resp_valid, 1'b0);
        tick(1);
        check("timeout_at_16", up_resp_valid, 1'b1);
        check("timeout_drop_ready", dm_resp_ready, 1'b1);
        tick(1);
        check("timeout_idle", busy, 1'b0);
    endtask

    initial begin
        rstn = 1'b1;
        up_req_valid = 1'b0; up_req_addr = '0; up_req_op = '0; up_req_data = '0;
        up_resp_ready = 1'b0; dm_req_ready = 1'b0;
        dm_resp_valid = 1'b0; dm_resp_resp = '0; dm_resp_data = '0;
        #2 rstn = 1'b0;
        tick(2);
        check("rst_up_req_ready", up_req_ready, 1'b1);
        check("rst_up_resp_valid", up_resp_valid, 1'b0);
        check("rst_dm_req_valid", dm_req_valid, 1'b0);
        check("rst_dm_resp_ready", dm_resp_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_cnt", timeout_cnt, 8'd0);
        rstn = 1'b1;
        tick(1);

        // Read with immediate dm ready, response 3 cycles later
        dm_req_ready  = 1'b1;
        up_resp_ready = 1'b1;
        txn(7'h11, 2'd1, 32'd0, 2, 2'd0, 32'hDEADBEEF);

        // Backpressure on both sides
        dm_req_ready = 1'b0;
        send_req(7'h22, 2'd2, 32'hA5A5_5A5A);
        tick(1);
        up_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_req_valid", dm_req_valid, 1'b1);
            check("bp_req_fields", {dm_req_addr, dm_req_op, dm_req_data}, {7'h22, 2'd2, 32'hA5A5_5A5A});
            check("bp_up_req_ready", up_req_ready, 1'b0);
            tick(1);
        end
        dm_q.push_back({7'h22, 2'd2, 32'hA5A5_5A5A});
        dm_req_ready  = 1'b1;
        up_resp_ready = 1'b0;
        tick(1);
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'h0BAD_F00D;
        tick(1);
        dm_resp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", up_resp_valid, 1'b1);
            check("bp_resp_fields", {up_resp_resp, up_resp_data}, {2'd0, 32'h0BAD_F00D});
            check("bp_up_req_ready2", up_req_ready, 1'b0);
            tick(1);
        end
        up_q.push_back({2'd0, 32'h0BAD_F00D});
        up_resp_ready = 1'b1;
        tick(1);
        check("bp_idle", busy, 1'b0);

        // Timeout with a silent debug module
        txn_timeout(7'h05, 2'd1);
        check("timeout_cnt_1", timeout_cnt, 8'd1);

        // Late response absorbed in IDLE, then a normal write
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'h0000_1234;
        tick(1);
        dm_resp_valid = 1'b0;
        check("late_dropped_ready", dm_resp_ready, 1'b0);
        check("late_no_up_resp", up_resp_valid, 1'b0);
        txn(7'h10, 2'd2, 32'hCAFE_0001, 1, 2'd0, 32'h0000_0055);

        // Response on the timeout cycle wins
        txn(7'h12, 2'd3, 32'h0000_0003, 15, 2'd0, 32'h7777_0001);
        check("tie_cnt_same", timeout_cnt, 8'd1);
        check("tie_no_drop", dm_resp_ready, 1'b0);

        // Busy response while a late response is outstanding
        txn_timeout(7'h06, 2'd0);
        check("timeout_cnt_2", timeout_cnt, 8'd2);
        up_q.push_back({2'd3, 32'd0});
        send_req(7'h33, 2'd1, 32'd0);
        tick(1);
        up_req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("hold_no_issue", dm_req_valid, 1'b0);
            check("hold_resp_ready", dm_resp_ready, 1'b1);
            check("hold_no_up_resp", up_resp_valid, 1'b0);
            tick(1);
        end
        check("busy_not_early", up_resp_valid, 1'b0);
        tick(1);
        check("busy_resp_valid", up_resp_valid, 1'b1);
        check("timeout_cnt_3", timeout_cnt, 8'd3);
        tick(1);
        check("busy_drop_kept", dm_resp_ready, 1'b1);
        dm_resp_valid = 1'b1; dm_resp_resp = 2'd0; dm_resp_data = 32'h0000_9999;
        tick(1);
        dm_resp_valid = 1'b0;
        check("drop_cleared", dm_resp_ready, 1'b0);

        // Reset in the middle of WAIT
        dm_q.push_back({7'h44, 2'd1, 32'd0});
        send_req(7'h44, 2'd1, 32'd0);
        tick(2);
        up_req_valid = 1'b0;
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_wait_ready", dm_resp_ready, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_up_req_ready", up_req_ready, 1'b1);
        check("mid_rst_dm_resp_ready", dm_resp_ready, 1'b0);
        check("mid_rst_up_resp_valid", up_resp_valid, 1'b0);
        check("mid_rst_cnt", timeout_cnt, 8'd0);
        tick(1);
        rstn = 1'b1;
        tick(1);
        txn(7'h11, 2'd1, 32'd0, 0, 2'd0, 32'h0000_600D);

        tick(2);
        check("up_q_empty", up_q.size(), 64'd0);
        check("dm_q_empty", dm_q.size(), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
